mmio_bus_router: RTL

//  Parametrised, registered address decoder / router between the core's data port and N memory-mapped slaves (RAM, UART, LED, ...).

---
 rtl/mmio_bus_router_pkg.sv | 26 ++
 rtl/mmio_bus_router_match.sv | 29 ++
 rtl/mmio_bus_router.sv | 154 +++++++++++++++
 3 files changed

// File: rtl/mmio_bus_router_pkg.sv
// Shared types and default memory map for the MMIO bus router.
// Default map: RAM at slot 0, UART at slot 1, LED at slot 2.
package mmio_bus_router_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_WAIT = 2'd1,
        ST_RESP = 2'd2
    } state_t;

    localparam logic [31:0] RAM_BASE  = 32'h0000_0000;
    localparam logic [31:0] UART_BASE = 32'h0040_0000;
    localparam logic [31:0] LED_BASE  = 32'h0040_0100;
    localparam logic [31:0] RAM_MASK  = 32'hFFC0_0000;
    localparam logic [31:0] UART_MASK = 32'hFFFF_FF00;
    localparam logic [31:0] LED_MASK  = 32'hFFFF_FFFC;

    // Flattened {LED, UART, RAM}: slot 0 sits in the low bits.
    localparam logic [95:0] DEF_SLV_BASE = {LED_BASE, UART_BASE, RAM_BASE};
    localparam logic [95:0] DEF_SLV_MASK = {LED_MASK, UART_MASK, RAM_MASK};

    function automatic int idx_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/mmio_bus_router_match.sv
// Combinational base/mask window compare; the lowest matching slot wins.
module addr_region_match
    import mmio_bus_router_pkg::*;
#(
    parameter int                      N_SLV    = 3,
    parameter int                      ADDR_W   = 32,
    parameter int                      IDX_W    = idx_width(N_SLV),
    parameter logic [N_SLV*ADDR_W-1:0] SLV_BASE = DEF_SLV_BASE,
    parameter logic [N_SLV*ADDR_W-1:0] SLV_MASK = DEF_SLV_MASK
) (
    input  logic [ADDR_W-1:0] addr,
    output logic              hit,
    output logic [IDX_W-1:0]  idx
);

    always_comb begin
        // NOTE: defaults first so every path assigns hit/idx and no latch is inferred.
        hit = 1'b0;
        idx = '0;
        // Walk downwards so a lower-index match overrides a higher one.
        for (int i = N_SLV - 1; i >= 0; i--) begin
            if ((addr & SLV_MASK[i*ADDR_W +: ADDR_W]) == SLV_BASE[i*ADDR_W +: ADDR_W]) begin
                hit = 1'b1;
                idx = IDX_W'(i);
            end
        end
    end

endmodule

// File: rtl/mmio_bus_router.sv
// Registered address decoder / router from the core data port to N MMIO slaves.
// Optional macro IO_DEC_ERR_LOG_EN adds err_addr/err_sticky fault logging.
module mmio_bus_router
    import mmio_bus_router_pkg::*;
#(
    parameter int                      N_SLV    = 3,
    parameter int                      ADDR_W   = 32,
    parameter int                      DATA_W   = 32,
    parameter int                      TIMEOUT  = 16,
    parameter logic [N_SLV*ADDR_W-1:0] SLV_BASE = DEF_SLV_BASE,
    parameter logic [N_SLV*ADDR_W-1:0] SLV_MASK = DEF_SLV_MASK
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    req_valid,
    output logic                    req_ready,
    input  logic [ADDR_W-1:0]       req_addr,
    input  logic                    req_we,
    input  logic [DATA_W-1:0]       req_wdata,
    input  logic [DATA_W/8-1:0]     req_wstrb,
    output logic                    rsp_valid,
    output logic [DATA_W-1:0]       rsp_rdata,
    output logic                    rsp_err,
`ifdef IO_DEC_ERR_LOG_EN
    output logic [ADDR_W-1:0]       err_addr,
    output logic                    err_sticky,
`endif
    output logic [N_SLV-1:0]        slv_sel,
    output logic [ADDR_W-1:0]       slv_addr,
    output logic                    slv_we,
    output logic [DATA_W-1:0]       slv_wdata,
    output logic [DATA_W/8-1:0]     slv_wstrb,
    input  logic [N_SLV-1:0]        slv_ready,
    input  logic [N_SLV*DATA_W-1:0] slv_rdata
);

    localparam int IDX_W = idx_width(N_SLV);
    localparam int CNT_W = (TIMEOUT > 2) ? $clog2(TIMEOUT) : 1;

    if (TIMEOUT < 2) begin : g_timeout_check
        $error("mmio_bus_router: TIMEOUT must be at least 2");
    end

    state_t             state;
    logic [IDX_W-1:0]   idx_q;
    logic [CNT_W-1:0]   cnt;
    logic               hit;
    logic [IDX_W-1:0]   hit_idx;
    logic [DATA_W-1:0]  sel_rdata;
    logic               sel_ready;

    addr_region_match #(
        .N_SLV    (N_SLV),
        .ADDR_W   (ADDR_W),
        .IDX_W    (IDX_W),
        .SLV_BASE (SLV_BASE),
        .SLV_MASK (SLV_MASK)
    ) u_match (
        .addr (req_addr),
        .hit  (hit),
        .idx  (hit_idx)
    );

    // Only the latched slave's ready and data are ever looked at.
    assign sel_rdata = slv_rdata[idx_q*DATA_W +: DATA_W];
    assign sel_ready = slv_ready[idx_q];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= ST_IDLE;
            req_ready <= 1'b1;
            rsp_valid <= 1'b0;
            rsp_err   <= 1'b0;
            rsp_rdata <= '0;
            slv_sel   <= '0;
            slv_addr  <= '0;
            slv_we    <= 1'b0;
            slv_wdata <= '0;
            slv_wstrb <= '0;
            idx_q     <= '0;
            cnt       <= '0;
        end else begin
            // NOTE: non-blocking assignments keep every register sampling pre-edge values.
            case (state)
                ST_IDLE: begin
                    if (req_valid) begin
                        slv_addr  <= req_addr;
                        slv_we    <= req_we;
                        slv_wdata <= req_wdata;
                        slv_wstrb <= req_wstrb;
                        req_ready <= 1'b0;
                        if (hit) begin
                            idx_q   <= hit_idx;
                            slv_sel <= N_SLV'(1) << hit_idx;
                            state   <= ST_WAIT;
                        end else begin
                            rsp_valid <= 1'b1;
                            rsp_err   <= 1'b1;
                            rsp_rdata <= '0;
                            state     <= ST_RESP;
                        end
                    end
                end
                ST_WAIT: begin
                    // A ready arriving in the final allowed cycle still counts as success.
                    if (sel_ready) begin
                        slv_sel   <= '0;
                        rsp_valid <= 1'b1;
                        rsp_err   <= 1'b0;
                        rsp_rdata <= slv_we ? '0 : sel_rdata;
                        state     <= ST_RESP;
                    end else if (cnt == CNT_W'(TIMEOUT - 1)) begin
                        slv_sel   <= '0;
                        rsp_valid <= 1'b1;
                        rsp_err   <= 1'b1;
                        rsp_rdata <= '0;
                        state     <= ST_RESP;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                ST_RESP: begin
                    rsp_valid <= 1'b0;
                    rsp_err   <= 1'b0;
                    rsp_rdata <= '0;
                    cnt       <= '0;
                    req_ready <= 1'b1;
                    state     <= ST_IDLE;
                end
                default: begin
                    slv_sel   <= '0;
                    rsp_valid <= 1'b0;
                    rsp_err   <= 1'b0;
                    cnt       <= '0;
                    req_ready <= 1'b1;
                    state     <= ST_IDLE;
                end
            endcase
        end
    end

`ifdef IO_DEC_ERR_LOG_EN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            err_addr   <= '0;
            err_sticky <= 1'b0;
        end else if (state == ST_RESP && rsp_err) begin
            err_addr   <= slv_addr;
            err_sticky <= 1'b1;
        end
    end
`endif

endmodule
